// File: rtl/rr_demux_scheduler.sv
// rr_demux_scheduler: steers one valid/ready stream onto NUM_OUT single-entry output channels
// Ports: clk/rst_n (sync, active-low), mode (0 rr, 1 directed), dest_sel, in_valid/in_data/in_ready,
//        out_valid/out_data/out_ready per channel, rr_ptr (next rr start), drop_cnt (illegal dest drops)
module rr_demux_scheduler #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          dest_sel,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    output logic [NUM_OUT-1:0]        out_valid,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [SEL_W-1:0]          rr_ptr,
    output logic [7:0]                drop_cnt
);
    logic [NUM_OUT-1:0]    avail;
    logic [2**SEL_W-1:0]   avail_x;
    logic [NUM_OUT-1:0]    wr_vec;
    logic [SEL_W-1:0]      rr_tgt;
    logic [SEL_W-1:0]      tgt;
    logic                  rr_hit;
    logic                  legal;
    logic                  acc;
    int                    best;
    int                    off;
    assign avail   = ~out_valid | out_ready;
    assign avail_x = (2**SEL_W)'(avail);
    assign legal   = int'(dest_sel) < NUM_OUT;
    assign tgt     = mode ? dest_sel : rr_tgt;
    assign in_ready = rst_n & (mode ? (~legal | avail_x[dest_sel]) : rr_hit);
    assign acc     = in_valid & in_ready;
    // Nearest available channel at or after rr_ptr, measured as circular distance.
    always_comb begin
        best   = NUM_OUT;
        off    = 0;
        rr_tgt = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            off = (k + NUM_OUT - int'(rr_ptr)) % NUM_OUT;
            if (avail[k] && off < best) begin
                best   = off;
                rr_tgt = SEL_W'(k);
            end
        end
        rr_hit = best < NUM_OUT;
    end
    always_comb begin
        wr_vec = '0;
        for (int k = 0; k < NUM_OUT; k++)
            wr_vec[k] = acc && (!mode || legal) && tgt == SEL_W'(k);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
            rr_ptr    <= '0;
            drop_cnt  <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (wr_vec[k]) begin
                    out_valid[k]                 <= 1'b1;
                    out_data[k*DATA_W +: DATA_W] <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (acc && !mode)
                rr_ptr <= SEL_W'((int'(rr_tgt) + 1) % NUM_OUT);
            if (acc && mode && !legal && drop_cnt != 8'hff)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_rr_demux_scheduler.sv
// tb_rr_demux_scheduler: directed stimulus with a channel-level reference model and literal checkpoints
module tb_rr_demux_scheduler;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int SW = 3;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic [SW-1:0] dest_sel = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [N-1:0]  out_valid;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]  out_ready = '0;
    logic [SW-1:0] rr_ptr;
    logic [7:0]    drop_cnt;
    int total = 0;
    int bad = 0;
    bit mv [N];
    int md [N];
    int mptr = 0;
    int mdrop = 0;
    logic [DW-1:0] ch2_seen [$];
    bit log_ch2 = 1'b0;
    rr_demux_scheduler #(.DATA_W(DW), .NUM_OUT(N), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .dest_sel(dest_sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .rr_ptr(rr_ptr), .drop_cnt(drop_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask
    // -1: nothing can be accepted; -2: accepted and discarded; else channel index.
    function automatic int mtarget();
        if (mode) begin
            if (int'(dest_sel) >= N) return -2;
            return (!mv[dest_sel] || out_ready[dest_sel]) ? int'(dest_sel) : -1;
        end
        for (int o = 0; o < N; o++)
            if (!mv[(mptr + o) % N] || out_ready[(mptr + o) % N]) return (mptr + o) % N;
        return -1;
    endfunction
    always @(posedge clk) begin
        int t;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin mv[k] = 0; md[k] = 0; end
            mptr = 0;
            mdrop = 0;
        end else begin
            t = mtarget();
            for (int k = 0; k < N; k++) if (out_ready[k]) mv[k] = 0;
            if (in_valid && t != -1) begin
                if (t == -2) mdrop = (mdrop == 255) ? 255 : mdrop + 1;
                else begin
                    mv[t] = 1;
                    md[t] = int'(in_data);
                    if (!mode) mptr = (t + 1) % N;
                end
            end
        end
    end
    always @(negedge clk) begin
        int vv;
        vv = 0;
        for (int k = 0; k < N; k++) vv |= int'(mv[k]) << k;
        chk("in_ready", int'(in_ready), rst_n ? int'(mtarget() != -1) : 0);
        chk("out_valid", int'(out_valid), vv);
        chk("rr_ptr", int'(rr_ptr), mptr);
        chk("drop_cnt", int'(drop_cnt), mdrop);
        for (int k = 0; k < N; k++)
            if (mv[k]) chk($sformatf("out_data%0d", k), int'(out_data[k*DW +: DW]), md[k]);
        if (log_ch2 && out_valid[2] && out_ready[2]) ch2_seen.push_back(out_data[2*DW +: DW]);
    end
    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    function automatic int dat(input int k);
        return int'(out_data[k*DW +: DW]);
    endfunction
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bit a;
        int n;
        in_valid = 1; in_data = 8'h11;
        cyc(2);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_rr_ptr", int'(rr_ptr), 0);
        rst_n = 1; out_ready = 4'b1111;
        #1 chk("rel_in_ready", int'(in_ready), 1);
        cyc();
        chk("first_beat_v", int'(out_valid), 4'b0001);
        chk("first_beat_d", dat(0), 8'h11);
        in_valid = 0; rst_n = 0;
        cyc();
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin in_valid = 1; in_data = DW'(8'hA0 + i); cyc(); end
        in_valid = 0;
        chk("rr6_ptr", int'(rr_ptr), 2);
        chk("rr6_valid", int'(out_valid), 4'b0010);
        chk("rr6_ch1", dat(1), 8'hA5);
        cyc();
        out_ready = 4'b1101;
        for (int i = 0; i < 3; i++) begin in_valid = 1; in_data = DW'(8'h30 + i); cyc(); end
        chk("pre_stall_ptr", int'(rr_ptr), 1);
        mode = 1; dest_sel = 1; in_data = 8'h44;
        cyc();
        mode = 0; in_data = 8'h55;
        cyc();
        in_valid = 0;
        chk("stall_ptr", int'(rr_ptr), 3);
        chk("stall_ch2", dat(2), 8'h55);
        cyc(2);
        chk("stall_hold_v", int'(out_valid[1]), 1);
        chk("stall_hold_d", dat(1), 8'h44);
        out_ready = 4'b1111;
        cyc();
        chk("stall_drain", int'(out_valid), 0);
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin in_valid = 1; in_data = DW'(8'hB0 + i); cyc(); end
        chk("full_valid", int'(out_valid), 4'b1111);
        in_data = 8'hB4;
        #1 chk("full_in_ready", int'(in_ready), 0);
        cyc();
        out_ready = 4'b1000;
        cyc();
        in_valid = 0;
        chk("refill_v", int'(out_valid), 4'b1111);
        chk("refill_d", dat(3), 8'hB4);
        chk("refill_ptr", int'(rr_ptr), 0);
        out_ready = 4'b1111;
        cyc(2);
        mode = 1; dest_sel = 2; log_ch2 = 1; n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            in_valid = 1; in_data = DW'(8'hC0 + n);
            out_ready[2] = (c % 2 == 0);
            #1 a = in_ready;
            cyc();
            if (a) n++;
        end
        in_valid = 0; out_ready = 4'b1111;
        cyc(2);
        log_ch2 = 0;
        chk("dir_count", n, 3);
        chk("dir_seen", ch2_seen.size(), 3);
        for (int i = 0; i < 3 && i < ch2_seen.size(); i++)
            chk($sformatf("dir_seen%0d", i), int'(ch2_seen[i]), 8'hC0 + i);
        chk("dir_ptr", int'(rr_ptr), 0);
        dest_sel = 5;
        for (int i = 0; i < 300; i++) begin in_valid = 1; in_data = DW'(i); cyc(); end
        chk("drop_sat", int'(drop_cnt), 255);
        chk("drop_valid", int'(out_valid), 0);
        out_ready = 4'b0000; mode = 0; in_data = 8'hD0;
        cyc();
        mode = 1; rst_n = 0;
        cyc();
        chk("midrst_drop", int'(drop_cnt), 0);
        chk("midrst_valid", int'(out_valid), 0);
        rst_n = 1; in_valid = 0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_demux_scheduler.md
Name: rr_demux_scheduler

Overview:
- Sequencing controller for the demux datapath: steers one valid/ready input stream onto NUM_OUT output channels, one beat per cycle max.
- Two modes: round-robin distribution (skips busy channels) or directed routing by dest_sel.
- Each output channel has a 1-entry holding register, so a stalled consumer blocks only its own channel.
- Sits between a single producer and a bank of parallel consumers/workers.

Parameters:
DATA_W, 8, payload width in bits
NUM_OUT, 4, number of output channels (legal 2..8)
SEL_W, 3, width of dest_sel and rr_ptr (must satisfy 2**SEL_W >= NUM_OUT)

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  synchronous reset, active-low (sampled on clk rising edge)
mode  input  1  0 = round-robin, 1 = directed by dest_sel
dest_sel  input  SEL_W  target channel in directed mode, sampled with in_valid
in_valid  input  1  input beat present
in_data  input  DATA_W  input payload
in_ready  output  1  input beat accepted this cycle when in_valid & in_ready
out_valid  output  NUM_OUT  per-channel holding register full
out_data  output  NUM_OUT*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W]
out_ready  input  NUM_OUT  per-channel consumer ready
rr_ptr  output  SEL_W  next round-robin start channel
drop_cnt  output  8  beats discarded for illegal dest_sel, saturating

Behaviour:
- Reset (rst_n low at clk edge): out_valid=0, out_data=0, rr_ptr=0, drop_cnt=0. Reset overrides everything; held/in-flight beats are lost. in_ready is 0 while rst_n is low.
- Slot k is "available" when out_valid[k]=0, or when out_valid[k]=1 and out_ready[k]=1 (draining this cycle).
- Handshake:
  - Output beat k transfers on out_valid[k] & out_ready[k]. out_valid[k] clears next cycle unless refilled the same cycle.
  - While out_valid[k]=1 and out_ready[k]=0, out_data[k] holds stable.
- Target selection, combinational, same cycle:
  - RR mode: target = first available channel scanning rr_ptr, rr_ptr+1, ... mod NUM_OUT. in_ready = any channel available.
  - Directed mode, dest_sel < NUM_OUT: target = dest_sel. in_ready = slot[dest_sel] available.
  - Directed mode, dest_sel >= NUM_OUT: in_ready = 1. An accepted beat is discarded (no output written) and drop_cnt increments, saturating at 255.
- On acceptance to a legal target t:
  - out_data[t] <= in_data; out_valid[t] <= 1.
  - The beat is visible on the outputs the next cycle (latency 1).
  - Simultaneous drain and refill of the same slot keeps out_valid[t]=1 with the new data; no bubble.
- rr_ptr:
  - Updates to (t+1) mod NUM_OUT only on an RR-mode acceptance.
  - Unchanged on directed acceptances, drops, and idle cycles.
- Mode and dest_sel may change on any cycle and take effect immediately; already-held beats are unaffected.
- At most one input beat is accepted per cycle; multiple channels may drain in the same cycle.
- in_ready depends combinationally on out_ready, mode and dest_sel, and must not depend on in_valid.
- No data loss or duplication: each accepted legal beat appears exactly once on exactly one channel.

Test Plan:
- Reset: rst_n=0 for 2 clk with in_valid=1 -> in_ready=0, out_valid=0000, rr_ptr=0, drop_cnt=0. Release -> first beat accepted on the next edge.
- RR all ready: out_ready=1111, mode=0, 6 beats 0xA0..0xA5 back-to-back -> each channel gets one beat per cycle in order ch0,1,2,3,0,1; rr_ptr ends at 2; in_ready stays 1.
- RR with stall: out_ready[1]=0, ch1 already full, rr_ptr=1 -> beat 0x55 goes to ch2, rr_ptr=3. ch1 data is held stable until out_ready[1]=1, then ch1 drains.
- Full backpressure: out_ready=0000, 4 beats fill ch0..3 -> in_ready=0 on the 5th beat. Raise out_ready[3] alone -> 5th beat lands in ch3 the same cycle it drains, and out_valid[3] stays 1.
- Directed mode: mode=1, dest_sel=2, 3 beats with out_ready[2] toggling 1,0,1 -> all 3 beats appear on ch2 in order; in_ready drops only while ch2 is full and stalled; rr_ptr unchanged.
- Illegal destination: mode=1, dest_sel=5, 300 beats -> in_ready=1 throughout, out_valid stays 0000, drop_cnt saturates at 255. Reset mid-stream clears drop_cnt and all slots.
